// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus initiator.
//   RAM_ADDR_WIDTH / RAM_DATA_WIDTH : default RAM geometry
//   RAM_LEN_WIDTH                   : burst length field width (beats minus one)
//   ram_bus_state_t                 : initiator FSM state encoding
package ram_bus_pkg;

   localparam int unsigned RAM_ADDR_WIDTH = 12;
   localparam int unsigned RAM_DATA_WIDTH = 8;
   localparam int unsigned RAM_LEN_WIDTH  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_ISSUE,
      ST_RD_CAP,
      ST_RD_HOLD
   } ram_bus_state_t;

endpackage

// File: rtl/ram_bus_tristate.sv
// Registered output enable and data driver for the bidirectional RAM data bus.
//   clk, rstn : clock, asynchronous active-low reset
//   oe_d      : next value of ram_oe (0 = this side drives the bus)
//   dout_d    : next value of the driven word
//   ram_oe    : registered RAM output enable
//   ram_data  : bidirectional bus, driven only while ram_oe is 0
module ram_bus_tristate
   import ram_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  oe_d,
   input  logic [DATA_WIDTH-1:0] dout_d,
   output logic                  ram_oe,
   inout  logic [DATA_WIDTH-1:0] ram_data
);

   logic                  oe_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  drive_en;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oe_q   <= 1'b1;
         dout_q <= '0;
      end else begin
         oe_q   <= oe_d;
         dout_q <= dout_d;
      end
   end

   // Driver enable comes from the very flop that drives ram_oe, so this side
   // and the RAM can never drive in the same cycle.
   assign drive_en = ~oe_q;
   assign ram_oe   = oe_q;
   assign ram_data = drive_en ? dout_q : 'z;

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for the single-port synchronous RAM bus.
// Turns valid/ready burst requests into registered cs/we/oe/addr bus cycles,
// drives write data onto the shared bus and returns read data on a
// backpressured response stream.
//   clk, rstn                     : clock, asynchronous active-low reset
//   req_valid/req_ready           : burst request handshake
//   req_we, req_addr, req_len     : direction, first address, beats minus one
//   wd_valid/wd_ready/wd_data     : write-data stream, one word per beat
//   rsp_valid/rsp_ready/rsp_data/rsp_last : read response stream
//   ram_cs, ram_we, ram_oe, ram_addr      : registered RAM controls
//   ram_data                      : bidirectional RAM data bus
// Optional: define RAM_BUS_MASTER_STATS_EN to add stat_beats, a 16-bit
// wrapping count of completed write beats and read response handshakes.
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [RAM_LEN_WIDTH-1:0] req_len,
   input  logic                     wd_valid,
   output logic                     wd_ready,
   input  logic [DATA_WIDTH-1:0]    wd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_data,
   output logic                     rsp_last,
   output logic                     ram_cs,
   output logic                     ram_we,
   output logic                     ram_oe,
   output logic [ADDR_WIDTH-1:0]    ram_addr,
   inout  logic [DATA_WIDTH-1:0]    ram_data
`ifdef RAM_BUS_MASTER_STATS_EN
   ,
   output logic [15:0]              stat_beats
`endif
);

   ram_bus_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
   logic [RAM_LEN_WIDTH-1:0] beat_q, beat_d;
   logic [RAM_LEN_WIDTH-1:0] len_q, len_d;
   logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
   logic                     ram_cs_q, ram_cs_d;
   logic                     ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0]    ram_addr_q, ram_addr_d;
   logic                     oe_d;
   logic                     last_beat;

   assign last_beat = (beat_q == len_q);

   // Bus controls are registered, so each state computes the pins that the
   // *next* cycle presents.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      beat_d     = beat_q;
      len_d      = len_q;
      rsp_data_d = rsp_data_q;
      ram_cs_d   = 1'b0;
      ram_we_d   = 1'b0;
      oe_d       = 1'b1;
      ram_addr_d = ram_addr_q;
      req_ready  = 1'b0;
      wd_ready   = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cur_addr_d = req_addr;
               len_d      = req_len;
               beat_d     = '0;
               if (req_we) begin
                  state_d = ST_WR;
               end else begin
                  state_d    = ST_RD_ISSUE;
                  ram_cs_d   = 1'b1;
                  ram_addr_d = req_addr;
               end
            end
         end
         ST_WR: begin
            wd_ready = 1'b1;
            if (wd_valid) begin
               ram_cs_d   = 1'b1;
               ram_we_d   = 1'b1;
               oe_d       = 1'b0;
               ram_addr_d = cur_addr_q;
               cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
               beat_d     = beat_q + RAM_LEN_WIDTH'(1);
               if (last_beat) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RD_ISSUE: begin
            ram_cs_d = 1'b1;
            state_d  = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            rsp_data_d = ram_data;
            state_d    = ST_RD_HOLD;
         end
         ST_RD_HOLD: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               if (last_beat) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_RD_ISSUE;
                  ram_cs_d   = 1'b1;
                  ram_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                  cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                  beat_d     = beat_q + RAM_LEN_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         beat_q     <= '0;
         len_q      <= '0;
         rsp_data_q <= '0;
         ram_cs_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         beat_q     <= beat_d;
         len_q      <= len_d;
         rsp_data_q <= rsp_data_d;
         ram_cs_q   <= ram_cs_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   ram_bus_tristate #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_tristate (
      .clk      (clk),
      .rstn     (rstn),
      .oe_d     (oe_d),
      .dout_d   (wd_data),
      .ram_oe   (ram_oe),
      .ram_data (ram_data)
   );

   assign rsp_data = rsp_data_q;
   assign rsp_last = (state_q == ST_RD_HOLD) && last_beat;
   assign ram_cs   = ram_cs_q;
   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;

`ifdef RAM_BUS_MASTER_STATS_EN
   logic [15:0] stat_q, stat_d;
   logic        beat_done;

   always_comb begin
      beat_done = ((state_q == ST_WR) && wd_valid) ||
                  ((state_q == ST_RD_HOLD) && rsp_ready);
      stat_d    = beat_done ? stat_q + 16'd1 : stat_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
module tb_ram_bus_master;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [3:0]    req_len = '0;
   logic          wd_valid = 1'b0;
   logic          wd_ready;
   logic [DW-1:0] wd_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic          ram_cs;
   logic          ram_we;
   logic          ram_oe;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;
`ifdef RAM_BUS_MASTER_STATS_EN
   logic [15:0]   stat_beats;
`endif

   ram_bus_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_oe    (ram_oe),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data)
`ifdef RAM_BUS_MASTER_STATS_EN
      ,
      .stat_beats(stat_beats)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous RAM: samples cs/we/addr on the rising edge, drives its read
   // register whenever ram_oe is high.
   logic [DW-1:0] mem [0:4095] = '{default: 8'h00};
   logic [DW-1:0] ram_rd_q = '0;

   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
      else if (ram_cs)      ram_rd_q <= mem[ram_addr];
   end

   assign ram_data = ram_oe ? ram_rd_q : 'z;

   // Reference model: expected memory contents plus expected beat count.
   logic [DW-1:0] ref_mem [0:4095];
   int            stat_exp = 0;
   logic [DW-1:0] wr_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int bus_viol = 0;

   // The master may drive only in write cycles, and every write cycle must
   // have the master driving.
   always @(negedge clk) begin
      if (rstn && ((!ram_oe) != (ram_cs && ram_we))) bus_viol <= bus_viol + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_ctrl"},
               {25'd0, req_ready, wd_ready, rsp_valid, rsp_last, ram_cs, ram_we, ram_oe},
               32'b1000001);
      check_eq({tag, "_regs"}, {12'd0, ram_addr, rsp_data}, 32'd0);
   endtask

   task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [3:0] len);
      int t;
      t = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_len   = len;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("req_accept", {31'd0, t < 50}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len, input int bubble_pct);
      int            beat;
      int            cyc;
      logic          v;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      send_req(1'b1, addr, len);
      beat = 0;
      cyc  = 0;
      while (beat <= int'(len) && cyc < 200) begin
         v = ($urandom_range(99) >= 32'(bubble_pct));
         d = (wr_q.size() != 0) ? wr_q[0] : DW'($urandom);
         wd_valid = v;
         wd_data  = d;
         @(negedge clk);
         cyc++;
         if (v) begin
            if (wr_q.size() != 0) void'(wr_q.pop_front());
            a = addr + AW'(beat);
            check_eq("wr_cycle", {9'd0, ram_cs, ram_we, ram_oe, ram_addr, ram_data},
                     {9'd0, 1'b1, 1'b1, 1'b0, a, d});
            ref_mem[a] = d;
            stat_exp++;
            beat++;
         end else begin
            check_eq("wr_bubble", {29'd0, ram_cs, ram_we, ram_oe}, 32'b001);
         end
      end
      wd_valid = 1'b0;
      check_eq("wr_budget", {31'd0, cyc < 200}, 32'd1);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len,
                          input int hold_max, input bit hold_fixed);
      int            n;
      int            hold;
      int            bad;
      int            rdcyc;
      logic          oe_ok;
      logic [AW-1:0] a;
      logic [9:0]    snap;
      send_req(1'b0, addr, len);
      rsp_ready = 1'b0;
      for (int beat = 0; beat <= int'(len); beat++) begin
         n     = 0;
         oe_ok = 1'b1;
         while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
            if (!ram_oe) oe_ok = 1'b0;
         end
         check_eq("rd_latency", n, 32'd2);
         check_eq("rd_oe_high", {31'd0, oe_ok}, 32'd1);
         a = addr + AW'(beat);
         check_eq("rd_rsp", {23'd0, rsp_last, rsp_data}, {23'd0, beat == int'(len), ref_mem[a]});
         hold  = hold_fixed ? hold_max : int'($urandom_range(hold_max, 0));
         snap  = {rsp_valid, rsp_last, rsp_data};
         bad   = 0;
         rdcyc = 0;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_last, rsp_data} !== snap) bad++;
            if (ram_cs) rdcyc++;
         end
         if (hold > 0) check_eq("rsp_hold", {bad[15:0], rdcyc[15:0]}, 32'd0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         stat_exp++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] d0, d1;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;
      @(negedge clk);

      // Full 16-beat write then read back, no stalls
      do_write(12'h000, 4'd15, 0);
      do_read(12'h000, 4'd15, 0, 1'b1);

      // Address wrap at the top of the RAM
      wr_q.push_back(8'hA5);
      wr_q.push_back(8'h5A);
      do_write(12'hFFF, 4'd1, 0);
      @(negedge clk);
      check_eq("wrap_mem_fff", {24'd0, mem[12'hFFF]}, 32'hA5);
      check_eq("wrap_mem_000", {24'd0, mem[12'h000]}, 32'h5A);
      do_read(12'hFFF, 4'd1, 0, 1'b1);

      // Response backpressure: 5 stalled cycles per beat
      do_read(12'h003, 4'd2, 5, 1'b1);

      // Write bubbles, then read back with random backpressure
      do_write(12'h100, 4'd9, 40);
      do_read(12'h100, 4'd9, 3, 1'b0);

      // Mixed random traffic
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(1) == 1)
            do_write(AW'($urandom), 4'($urandom), int'($urandom_range(50)));
         else
            do_read(AW'($urandom), 4'($urandom), 3, 1'b0);
      end

      // Reset during beat 3 of a write: beats 0 and 1 reach the RAM, beat 2 is
      // still on the bus when reset hits and must not be written.
      send_req(1'b1, 12'h200, 4'd7);
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      wd_valid = 1'b1;
      wd_data  = d0;
      @(negedge clk);
      wd_data  = d1;
      @(negedge clk);
      wd_data  = DW'($urandom);
      @(negedge clk);
      wd_data  = DW'($urandom);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_values("async_reset");
      ref_mem[12'h200] = d0;
      ref_mem[12'h201] = d1;
      stat_exp = 0;
      wd_valid = 1'b0;
      @(negedge clk);
      check_reset_values("reset_hold");
      rstn = 1'b1;
      @(negedge clk);
      do_read(12'h201, 4'd0, 0, 1'b1);
      do_read(12'h200, 4'd2, 1, 1'b0);

      @(negedge clk);
      check_eq("bus_excl", bus_viol, 32'd0);
`ifdef RAM_BUS_MASTER_STATS_EN
      check_eq("stat_beats", {16'd0, stat_beats}, {16'd0, stat_exp[15:0]});
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
